// File: rtl/uart_tx_frame_gen.sv
// UART transmit framer: pops bytes from a show-ahead FIFO and serialises them LSB-first
// with a start bit, an optional even parity bit and one or two stop bits, with no idle gap between frames.
module uart_tx_frame_gen #(
  parameter int DATA_W = 8,
  parameter int CD_W   = 13
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              TXen,
  input  logic              parity_bit_mode,
  input  logic              stop_bit_twice,
  input  logic [3:0]        number_data_transmit,
  input  logic [CD_W-1:0]   cd,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_data,
  output logic              fifo_rd_ctrl,
  output logic              UART_TXD,
  output logic              tx_busy,
  output logic              tx_done
);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t            state_q, state_d;
  logic [CD_W-1:0]   baud_q, baud_d;
  logic [3:0]        bit_q, bit_d;
  logic [CD_W-1:0]   cd_lat_q;
  logic [3:0]        n_lat_q;
  logic [DATA_W-1:0] data_lat_q;
  logic [DATA_W-1:0] data_sh;
  logic              par_lat_q, stop2_lat_q;
  logic              bit_end, launch;

  function automatic logic [3:0] eff_width(input logic [3:0] n);
    case (n)
      4'd6, 4'd7, 4'd8: return n;
      default:          return 4'd5;
    endcase
  endfunction

  function automatic logic [CD_W-1:0] eff_cd(input logic [CD_W-1:0] c);
    return (c == '0) ? CD_W'(1) : c;
  endfunction

  function automatic logic even_parity(input logic [DATA_W-1:0] d, input logic [3:0] n);
    logic p;
    p = 1'b0;
    for (int i = 0; i < DATA_W; i++)
      if (i < int'(n)) p ^= d[i];
    return p;
  endfunction

  assign bit_end = (baud_q == cd_lat_q - CD_W'(1));
  assign data_sh = data_lat_q >> bit_q;
  assign tx_busy = (state_q != IDLE);

  always_comb begin
    state_d  = state_q;
    bit_d    = bit_q;
    baud_d   = bit_end ? '0 : baud_q + CD_W'(1);
    launch   = 1'b0;
    tx_done  = 1'b0;
    UART_TXD = 1'b1;
    case (state_q)
      IDLE: begin
        baud_d = '0;
        if (TXen && !fifo_empty) begin
          launch  = 1'b1;
          state_d = START;
        end
      end
      START: begin
        UART_TXD = 1'b0;
        if (bit_end) begin
          state_d = DATA;
          bit_d   = '0;
        end
      end
      DATA: begin
        UART_TXD = data_sh[0];
        if (bit_end) begin
          if (bit_q == n_lat_q - 4'd1) begin
            bit_d   = '0;
            state_d = par_lat_q ? PARITY : STOP;
          end else begin
            bit_d = bit_q + 4'd1;
          end
        end
      end
      PARITY: begin
        UART_TXD = even_parity(data_lat_q, n_lat_q);
        if (bit_end) state_d = STOP;
      end
      STOP: begin
        if (bit_end) begin
          // bit_q counts completed stop bits; the second one only exists in 2-stop mode
          if (stop2_lat_q && bit_q == 4'd0) begin
            bit_d = 4'd1;
          end else begin
            tx_done = 1'b1;
            bit_d   = '0;
            if (TXen && !fifo_empty) begin
              launch  = 1'b1;
              state_d = START;
            end else begin
              state_d = IDLE;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (rst_i) begin
      launch  = 1'b0;
      tx_done = 1'b0;
    end
    fifo_rd_ctrl = launch;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
    end
  end

  // Frame configuration is captured at the pop so mid-frame changes only affect the next frame
  always_ff @(posedge clk_i) begin
    if (launch) begin
      data_lat_q  <= fifo_data;
      n_lat_q     <= eff_width(number_data_transmit);
      par_lat_q   <= parity_bit_mode;
      stop2_lat_q <= stop_bit_twice;
      cd_lat_q    <= eff_cd(cd);
    end
  end

endmodule

// File: tb/tb_uart_tx_frame_gen.sv
// Bench for uart_tx_frame_gen: a FIFO model feeds the DUT and every line cycle is compared
// against a waveform built from the frame rules (start, N data bits, parity, stop bits, each cd cycles).
module tb_uart_tx_frame_gen;
  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        TXen = 1'b0;
  logic        parity_bit_mode = 1'b0;
  logic        stop_bit_twice = 1'b0;
  logic [3:0]  number_data_transmit = 4'd8;
  logic [12:0] cd = 13'd4;
  logic        fifo_empty;
  logic [7:0]  fifo_data;
  logic        fifo_rd_ctrl, UART_TXD, tx_busy, tx_done;

  int total = 0;
  int bad = 0;

  logic [7:0] fmem [256];
  int   wr_ptr = 0;
  int   rd_ptr = 0;
  logic empty_pop = 1'b0;

  bit exp_line[$];
  int exp_done[$];

  uart_tx_frame_gen #(.DATA_W(8), .CD_W(13)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .TXen(TXen), .parity_bit_mode(parity_bit_mode),
    .stop_bit_twice(stop_bit_twice), .number_data_transmit(number_data_transmit), .cd(cd),
    .fifo_empty(fifo_empty), .fifo_data(fifo_data), .fifo_rd_ctrl(fifo_rd_ctrl),
    .UART_TXD(UART_TXD), .tx_busy(tx_busy), .tx_done(tx_done)
  );

  always #5 clk_i = ~clk_i;

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_data  = fmem[rd_ptr % 256];

  always @(posedge clk_i) begin
    if (fifo_rd_ctrl) begin
      if (fifo_empty) empty_pop <= 1'b1;
      else rd_ptr <= rd_ptr + 1;
    end
  end

  task automatic push(input logic [7:0] b);
    fmem[wr_ptr % 256] = b;
    wr_ptr++;
  endtask

  // Expected line waveform of one frame, appended to exp_line
  function automatic void model_frame(input logic [7:0] b, input int ndt, input bit par,
                                      input bit st2, input int cdv);
    int n;
    int c;
    bit p;
    bit seq[$];
    n = (ndt >= 6 && ndt <= 8) ? ndt : 5;
    c = (cdv == 0) ? 1 : cdv;
    p = 1'b0;
    seq.push_back(1'b0);
    for (int k = 0; k < n; k++) begin
      seq.push_back(b[k]);
      p ^= b[k];
    end
    if (par) seq.push_back(p);
    seq.push_back(1'b1);
    if (st2) seq.push_back(1'b1);
    foreach (seq[j])
      for (int r = 0; r < c; r++) exp_line.push_back(seq[j]);
    exp_done.push_back(exp_line.size() - 1);
  endfunction

  // Waits for the launch pop, then checks every cycle of the back-to-back frames and the idle cycle after.
  // act 1 drops TXen, act 2 changes cd to 8, right after cycle act_cyc is checked.
  task automatic run_check(input string name, input logic [7:0] bytes[$], input int act_cyc, input int act);
    int w;
    exp_line.delete();
    exp_done.delete();
    foreach (bytes[k])
      model_frame(bytes[k], int'(number_data_transmit), parity_bit_mode, stop_bit_twice, int'(cd));
    w = 0;
    #1;
    while (!fifo_rd_ctrl && w < 100) begin
      @(negedge clk_i);
      #1;
      w++;
    end
    total++;
    if (fifo_rd_ctrl !== 1'b1) begin
      bad++;
      $display("FAIL %s launch: fifo_rd_ctrl=%b, required 1 within 100 cycles", name, fifo_rd_ctrl);
      return;
    end
    for (int i = 0; i < exp_line.size(); i++) begin
      bit is_end;
      bit exp_pop;
      int fidx;
      is_end = 1'b0;
      fidx = -1;
      @(negedge clk_i);
      foreach (exp_done[f])
        if (exp_done[f] == i) begin
          is_end = 1'b1;
          fidx = f;
        end
      exp_pop = is_end && (fidx < exp_done.size() - 1);
      total++;
      if (UART_TXD !== exp_line[i]) begin
        bad++;
        $display("FAIL %s txd cycle %0d: got %b, required %b", name, i, UART_TXD, exp_line[i]);
      end
      total++;
      if (tx_busy !== 1'b1) begin
        bad++;
        $display("FAIL %s busy cycle %0d: got %b, required 1", name, i, tx_busy);
      end
      total++;
      if (tx_done !== is_end) begin
        bad++;
        $display("FAIL %s done cycle %0d: got %b, required %b", name, i, tx_done, is_end);
      end
      total++;
      if (fifo_rd_ctrl !== exp_pop) begin
        bad++;
        $display("FAIL %s pop cycle %0d: got %b, required %b", name, i, fifo_rd_ctrl, exp_pop);
      end
      if (i == act_cyc) begin
        if (act == 1) TXen = 1'b0;
        else if (act == 2) cd = 13'd8;
      end
    end
    @(negedge clk_i);
    total++;
    if (UART_TXD !== 1'b1 || tx_busy !== 1'b0 || tx_done !== 1'b0 || fifo_rd_ctrl !== 1'b0) begin
      bad++;
      $display("FAIL %s idle after frame: txd/busy/done/pop got %b%b%b%b, required 1000",
               name, UART_TXD, tx_busy, tx_done, fifo_rd_ctrl);
    end
  endtask

  task automatic set_cfg(input int ndt, input bit par, input bit st2, input int cdv);
    number_data_transmit = 4'(ndt);
    parity_bit_mode = par;
    stop_bit_twice = st2;
    cd = 13'(cdv);
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    TXen = 1'b0;
    repeat (3) @(negedge clk_i);
    total++;
    if (UART_TXD !== 1'b1 || tx_busy !== 1'b0 || tx_done !== 1'b0 || fifo_rd_ctrl !== 1'b0) begin
      bad++;
      $display("FAIL reset values: txd/busy/done/pop got %b%b%b%b, required 1000",
               UART_TXD, tx_busy, tx_done, fifo_rd_ctrl);
    end
    rst_i = 1'b0;
    @(negedge clk_i);
    total++;
    if (UART_TXD !== 1'b1 || tx_busy !== 1'b0) begin
      bad++;
      $display("FAIL idle after reset: txd/busy got %b%b, required 10", UART_TXD, tx_busy);
    end
  endtask

  task automatic test_8n1();
    logic [7:0] q[$];
    set_cfg(8, 0, 0, 4);
    q.push_back(8'hA5);
    push(8'hA5);
    TXen = 1'b1;
    run_check("8n1", q, -1, 0);
  endtask

  task automatic test_7e2();
    logic [7:0] q[$];
    set_cfg(7, 1, 1, 2);
    q.push_back(8'h35);
    push(8'h35);
    run_check("7e2", q, -1, 0);
  endtask

  task automatic test_width();
    logic [7:0] q[$];
    set_cfg(5, 0, 0, 3);
    q.push_back(8'hFF);
    push(8'hFF);
    run_check("width5", q, -1, 0);
    q.delete();
    set_cfg(3, 0, 0, 3);
    q.push_back(8'hE1);
    push(8'hE1);
    run_check("width3_as5", q, -1, 0);
  endtask

  task automatic test_back_to_back();
    logic [7:0] q[$];
    set_cfg(8, 0, 0, 3);
    q.push_back(8'h00);
    q.push_back(8'hFF);
    push(8'h00);
    push(8'hFF);
    run_check("back_to_back", q, -1, 0);
  endtask

  task automatic test_gating();
    logic [7:0] q[$];
    set_cfg(8, 0, 0, 4);
    TXen = 1'b0;
    push(8'h5A);
    repeat (8) begin
      @(negedge clk_i);
      total++;
      if (fifo_rd_ctrl !== 1'b0 || UART_TXD !== 1'b1) begin
        bad++;
        $display("FAIL txen_off: pop/txd got %b%b, required 01", fifo_rd_ctrl, UART_TXD);
      end
    end
    q.push_back(8'h5A);
    TXen = 1'b1;
    run_check("txen_on", q, -1, 0);

    q.delete();
    push(8'h3C);
    push(8'hC3);
    q.push_back(8'h3C);
    run_check("txen_drop", q, 5, 1);
    repeat (10) begin
      @(negedge clk_i);
      total++;
      if (fifo_rd_ctrl !== 1'b0 || UART_TXD !== 1'b1 || tx_busy !== 1'b0) begin
        bad++;
        $display("FAIL txen_dropped idle: pop/txd/busy got %b%b%b, required 010",
                 fifo_rd_ctrl, UART_TXD, tx_busy);
      end
    end
    q.delete();
    q.push_back(8'hC3);
    TXen = 1'b1;
    run_check("txen_resume", q, -1, 0);

    q.delete();
    set_cfg(8, 0, 0, 4);
    q.push_back(8'h96);
    push(8'h96);
    run_check("cd_change", q, 3, 2);
    cd = 13'd4;
  endtask

  task automatic test_reset_mid();
    logic [7:0] q[$];
    int w;
    int saved_rd;
    set_cfg(8, 0, 0, 4);
    TXen = 1'b1;
    push(8'h69);
    w = 0;
    #1;
    while (!fifo_rd_ctrl && w < 100) begin
      @(negedge clk_i);
      #1;
      w++;
    end
    total++;
    if (fifo_rd_ctrl !== 1'b1) begin
      bad++;
      $display("FAIL reset_mid launch: fifo_rd_ctrl=%b, required 1", fifo_rd_ctrl);
      return;
    end
    repeat (10) @(negedge clk_i);
    push(8'h96);
    rst_i = 1'b1;
    saved_rd = rd_ptr;
    @(negedge clk_i);
    total++;
    if (UART_TXD !== 1'b1 || tx_busy !== 1'b0 || tx_done !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid abort: txd/busy/done got %b%b%b, required 100", UART_TXD, tx_busy, tx_done);
    end
    repeat (2) begin
      total++;
      if (fifo_rd_ctrl !== 1'b0) begin
        bad++;
        $display("FAIL reset_mid pop during reset: got %b, required 0", fifo_rd_ctrl);
      end
      @(negedge clk_i);
    end
    total++;
    if (rd_ptr != saved_rd) begin
      bad++;
      $display("FAIL reset_mid fifo reads: got %0d, required %0d", rd_ptr, saved_rd);
    end
    rst_i = 1'b0;
    q.push_back(8'h96);
    run_check("after_reset", q, -1, 0);
  endtask

  task automatic test_cd0();
    logic [7:0] q[$];
    set_cfg(8, 1, 0, 0);
    q.push_back(8'hB7);
    push(8'hB7);
    run_check("cd0", q, -1, 0);
  endtask

  task automatic test_random();
    logic [7:0] q[$];
    logic [7:0] b;
    int nf;
    for (int it = 0; it < 12; it++) begin
      q.delete();
      set_cfg(int'($urandom_range(0, 15)), 1'($urandom), 1'($urandom), int'($urandom_range(0, 5)));
      nf = int'($urandom_range(1, 3));
      for (int k = 0; k < nf; k++) begin
        b = 8'($urandom);
        q.push_back(b);
        push(b);
      end
      run_check("random", q, -1, 0);
    end
  endtask

  initial begin
    test_reset();
    test_8n1();
    test_7e2();
    test_width();
    test_back_to_back();
    test_gating();
    test_reset_mid();
    test_cd0();
    test_random();
    total++;
    if (empty_pop !== 1'b0) begin
      bad++;
      $display("FAIL pop_when_empty: got %b, required 0", empty_pop);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
